// File: rtl/uart_rx_os.sv
// UART receiver, 16x oversampled via shared baud tick i_bd.
// Frame: 1 start bit, DATA_BITS data bits (LSB first), 1 stop bit.
// Ports:
//   i_clock      system clock, rising edge
//   i_reset      synchronous active-high reset
//   i_bd         oversampling tick, OS_TICKS per bit period
//   i_rx_serial  asynchronous serial line, idle high
//   o_rx_byte    last received data word
//   o_rx_done    one-cycle strobe, o_rx_byte/o_frame_err valid
//   o_rx_active  high while a frame is being received
//   o_frame_err  stop bit sampled low in the last frame
module uart_rx_os #(
   parameter int DATA_BITS = 8,
   parameter int OS_TICKS  = 16,
   parameter int SB_TICKS  = 16
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_bd,
   input  logic                 i_rx_serial,
   output logic [DATA_BITS-1:0] o_rx_byte,
   output logic                 o_rx_done,
   output logic                 o_rx_active,
   output logic                 o_frame_err
);

   localparam int TW = $clog2(OS_TICKS);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [TW-1:0] T_MID  = TW'(OS_TICKS / 2 - 1);
   localparam logic [TW-1:0] T_END  = TW'(OS_TICKS - 1);
   localparam logic [TW-1:0] T_STOP = TW'(SB_TICKS - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t               state;
   logic [TW-1:0]        tick_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 rx_m;
   logic                 rx_s;

   // Synchronizer flops reset to the idle line level so reset
   // never looks like a start bit.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= i_rx_serial;
         rx_s <= rx_m;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state       <= IDLE;
         tick_cnt    <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         o_rx_byte   <= '0;
         o_rx_done   <= 1'b0;
         o_rx_active <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         o_rx_done <= 1'b0;
         case (state)
            IDLE: begin
               // Start detection runs every clock, not only on i_bd.
               if (!rx_s) begin
                  state       <= START;
                  tick_cnt    <= '0;
                  o_rx_active <= 1'b1;
               end
            end
            START: begin
               if (i_bd) begin
                  if (tick_cnt == T_MID) begin
                     if (!rx_s) begin
                        state    <= DATA;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                     end else begin
                        state       <= IDLE;
                        o_rx_active <= 1'b0;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TW'(1);
                  end
               end
            end
            DATA: begin
               if (i_bd) begin
                  if (tick_cnt == T_END) begin
                     shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                     tick_cnt <= '0;
                     if (bit_cnt == B_LAST) begin
                        state <= STOP;
                     end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TW'(1);
                  end
               end
            end
            STOP: begin
               // Leave at mid stop bit so an adjacent start bit
               // is still caught in IDLE.
               if (i_bd) begin
                  if (tick_cnt == T_STOP) begin
                     o_rx_byte   <= shreg;
                     o_frame_err <= ~rx_s;
                     o_rx_done   <= 1'b1;
                     o_rx_active <= 1'b0;
                     state       <= IDLE;
                  end else begin
                     tick_cnt <= tick_cnt + TW'(1);
                  end
               end
            end
            default: begin
               state       <= IDLE;
               o_rx_active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed scenarios plus
// randomized frames against a sequential timing model.
module tb_uart_rx_os;

   localparam int DB = 8;
   localparam int OS = 16;
   localparam int SB = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       bd  = 1'b0;
   logic       rx  = 1'b1;
   logic [7:0] byte_o;
   logic       done;
   logic       active;
   logic       ferr;

   uart_rx_os #(
      .DATA_BITS(DB),
      .OS_TICKS(OS),
      .SB_TICKS(SB)
   ) dut (
      .i_clock(clk),
      .i_reset(rst),
      .i_bd(bd),
      .i_rx_serial(rx),
      .o_rx_byte(byte_o),
      .o_rx_done(done),
      .o_rx_active(active),
      .o_frame_err(ferr)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   bd_per = 1;
   bit   chk_en = 0;
   bit   active_seen = 0;
   logic [8:0] dut_q[$];
   logic [8:0] mdl_q[$];

   logic       m_s1 = 1'b1;
   logic       m_s2 = 1'b1;
   logic [7:0] e_byte;
   logic       e_done;
   logic       e_active;
   logic       e_err;

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
      end
   endtask

   // Model: the line as seen two clocks late.
   always @(posedge clk) begin
      if (rst) begin
         m_s1 <= 1'b1;
         m_s2 <= 1'b1;
      end else begin
         m_s1 <= rx;
         m_s2 <= m_s1;
      end
   end

   task automatic set_rst();
      e_byte   = '0;
      e_err    = 1'b0;
      e_done   = 1'b0;
      e_active = 1'b0;
   endtask

   // Wait for the n-th i_bd pulse and return the line at it.
   task automatic count_bd(input int n, output logic v, output bit ab);
      int c;
      c  = 0;
      ab = 0;
      v  = 1'b1;
      while (c < n) begin
         @(posedge clk);
         if (rst) begin
            set_rst();
            ab = 1;
            return;
         end
         e_done = 1'b0;
         if (bd) begin
            c++;
            if (c == n) v = m_s2;
         end
      end
   endtask

   initial begin : model
      logic       v;
      bit         ab;
      logic [7:0] d;
      d = '0;
      set_rst();
      forever begin
         @(posedge clk);
         if (rst) begin
            set_rst();
            continue;
         end
         e_done = 1'b0;
         if (m_s2 === 1'b0) begin
            e_active = 1'b1;
            count_bd(OS / 2, v, ab);
            if (ab) continue;
            if (v) begin
               e_active = 1'b0;
               continue;
            end
            for (int i = 0; i < DB; i++) begin
               count_bd(OS, v, ab);
               if (ab) break;
               d[i] = v;
            end
            if (ab) continue;
            count_bd(SB, v, ab);
            if (ab) continue;
            e_byte   = d;
            e_err    = ~v;
            e_done   = 1'b1;
            e_active = 1'b0;
            mdl_q.push_back({~v, d});
         end
      end
   end

   initial begin : compare
      forever begin
         @(posedge clk);
         #1;
         if (chk_en)
            chk("cycle", {done, active, ferr, byte_o},
                {e_done, e_active, e_err, e_byte});
         if (done) dut_q.push_back({ferr, byte_o});
         if (active) active_seen = 1;
      end
   end

   initial begin : bdgen
      int bcnt;
      bcnt = 0;
      forever begin
         @(negedge clk);
         bcnt++;
         if (bcnt >= bd_per) begin
            bcnt = 0;
            bd   = 1'b1;
         end else begin
            bd = 1'b0;
         end
      end
   end

   task automatic hold(input logic v, input int n);
      rx = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic idle(input int n);
      hold(1'b1, n);
   endtask

   // A bad stop bit is low for 3/4 of its period, then high.
   task automatic send(input logic [7:0] b, input bit stop);
      int bt;
      bt = OS * bd_per;
      hold(1'b0, bt);
      for (int i = 0; i < DB; i++) hold(b[i], bt);
      if (stop) begin
         hold(1'b1, bt);
      end else begin
         hold(1'b0, bt * 3 / 4);
         hold(1'b1, bt - bt * 3 / 4);
      end
   endtask

   task automatic clr();
      dut_q.delete();
      mdl_q.delete();
      active_seen = 0;
   endtask

   task automatic chk_rx(input string n, input int idx,
                         input logic [8:0] e);
      logic [31:0] g;
      g = (idx < dut_q.size()) ? {23'd0, dut_q[idx]} : 32'hFFFF;
      chk(n, g, {23'd0, e});
      g = (idx < mdl_q.size()) ? {23'd0, mdl_q[idx]} : 32'hFFFF;
      chk({n, "_model"}, g, {23'd0, e});
   endtask

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin : main
      logic [7:0] rb;
      bit         rs;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_byte", byte_o, 0);
      chk("rst_done", done, 0);
      chk("rst_active", active, 0);
      chk("rst_err", ferr, 0);
      chk_en = 1;
      idle(10);

      clr();
      send(8'hA5, 1);
      idle(20);
      chk("a5_active_seen", active_seen, 1);
      chk("a5_count", dut_q.size(), 1);
      chk_rx("a5", 0, {1'b0, 8'hA5});
      chk("a5_active_after", active, 0);

      clr();
      hold(1'b0, 4);
      idle(30);
      chk("glitch_active_seen", active_seen, 1);
      chk("glitch_count", dut_q.size(), 0);
      chk("glitch_byte", byte_o, 8'hA5);
      chk("glitch_active", active, 0);

      clr();
      send(8'h3C, 0);
      idle(20);
      send(8'h55, 1);
      idle(20);
      chk("ferr_count", dut_q.size(), 2);
      chk_rx("ferr_3c", 0, {1'b1, 8'h3C});
      chk_rx("ferr_55", 1, {1'b0, 8'h55});

      clr();
      send(8'h00, 1);
      send(8'hFF, 1);
      idle(20);
      chk("b2b_count", dut_q.size(), 2);
      chk_rx("b2b_00", 0, {1'b0, 8'h00});
      chk_rx("b2b_ff", 1, {1'b0, 8'hFF});

      bd_per = 5;
      idle(20);
      clr();
      send(8'h81, 1);
      idle(100);
      chk_rx("slow_81", 0, {1'b0, 8'h81});
      chk("slow_byte", byte_o, 8'h81);

      clr();
      fork
         send(8'hF8, 1);
         begin
            repeat (4 * OS * 5 + OS * 5 / 2) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("midrst_active", active, 0);
            chk("midrst_byte", byte_o, 0);
            chk("midrst_done", done, 0);
         end
      join
      idle(100);
      chk("midrst_count", dut_q.size(), 0);

      clr();
      send(8'h7E, 1);
      idle(100);
      chk_rx("after_rst_7e", 0, {1'b0, 8'h7E});

      clr();
      for (int k = 0; k < 40; k++) begin
         bd_per = $urandom_range(1, 3);
         idle(OS * bd_per);
         if ($urandom_range(0, 7) == 0) begin
            hold(1'b0, $urandom_range(1, 4));
            idle(OS * bd_per);
         end
         rb = 8'($urandom);
         rs = ($urandom_range(0, 3) != 0);
         send(rb, rs);
         idle($urandom_range(0, 10));
      end
      idle(200);
      chk("rand_count", dut_q.size(), mdl_q.size());
      chk("rand_nonzero", (dut_q.size() > 20) ? 1 : 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- UART receiver; the counterpart of the team's UART transmitter on the same serial link.
- Oversamples the serial line using the shared baud-rate tick i_bd, which pulses at 16x the bit rate.
- Decodes frames of 1 start bit, DATA_BITS data bits sent LSB first, and 1 stop bit.
- Presents each received byte with a one-cycle done strobe and a framing-error flag to the downstream interface logic.

Parameters:
- DATA_BITS, 8, number of data bits per frame.
- OS_TICKS, 16, i_bd ticks per bit period. Must be a power of 2 and at least 8.
- SB_TICKS, 16, i_bd ticks counted in the stop state, from mid-last-data-bit to mid-stop-bit.

Ports:
- i_clock  in  1  system clock, rising-edge.
- i_reset  in  1  reset, synchronous, active-high.
- i_bd  in  1  oversampling tick, one i_clock cycle wide, OS_TICKS per bit.
- i_rx_serial  in  1  asynchronous serial line, idle high.
- o_rx_byte  out  DATA_BITS  last received data word.
- o_rx_done  out  1  one-cycle strobe: o_rx_byte and o_frame_err are valid.
- o_rx_active  out  1  high while a frame is being received.
- o_frame_err  out  1  stop bit sampled low in the last frame.

Behaviour:
- i_rx_serial passes through a 2-flop synchronizer. Both flops reset to 1. All decoding uses the synchronizer output rx_s, so line-to-FSM latency is 2 cycles.
- State registers:
  - state: IDLE, START, DATA, STOP.
  - tick_cnt: log2(OS_TICKS) bits.
  - bit_cnt: log2(DATA_BITS) bits.
  - shift register: DATA_BITS bits.
- All registers are updated only on the i_clock rising edge. There is no combinational feedback and no latches.
- Reset values: state=IDLE, all counters 0, shift register 0, o_rx_byte=0, o_rx_done=0, o_rx_active=0, o_frame_err=0.
- Reset is honoured in any state, including mid-frame. The partial frame is discarded and no o_rx_done is produced.
- IDLE:
  - When rx_s==0, go to START and clear tick_cnt. i_bd is not required for this transition.
- START:
  - On each i_bd, tick_cnt increments.
  - At the i_bd where tick_cnt==OS_TICKS/2-1 (mid start bit):
    - If rx_s==0: go to DATA, clear tick_cnt and bit_cnt.
    - If rx_s==1: false start. Return to IDLE with no strobe.
- DATA:
  - On each i_bd, tick_cnt increments.
  - At the i_bd where tick_cnt==OS_TICKS-1 (mid data bit):
    - Shift rx_s into the MSB of the shift register, shifting right, so the first bit received lands in bit 0.
    - Clear tick_cnt.
    - If bit_cnt==DATA_BITS-1, go to STOP. Otherwise increment bit_cnt.
- STOP:
  - On each i_bd, tick_cnt increments.
  - At the i_bd where tick_cnt==SB_TICKS-1, on that same edge:
    - o_rx_byte <= shift register.
    - o_frame_err <= ~rx_s.
    - o_rx_done <= 1.
    - Go to IDLE.
  - The frame is accepted even on a framing error.
- o_rx_done is high for exactly one i_clock cycle per frame and is cleared on the next edge.
- o_rx_byte and o_frame_err hold their values until the next completed frame.
- o_rx_active is registered. It is 1 when the registered state is START, DATA or STOP, and 0 in IDLE.
- Between i_bd pulses, all counters and state hold. The only exception is the IDLE-to-START transition.
- Back-to-back frames: the return to IDLE happens at mid stop bit, so a start bit immediately following the stop bit is detected with no lost frame.
- The break condition (line held low) produces repeated frames of 0x00 with o_frame_err=1 and is not otherwise flagged.
- The FSM state encoding is 2 bits. Any unreachable encoding returns to IDLE.

Test Plan:
- Bench setup: i_bd=1 every cycle (bit = 16 clocks, DATA_BITS=8). Reset for 3 cycles, then send byte 0xA5 with a valid stop bit.
  - Required: o_rx_active rises, then one o_rx_done pulse with o_rx_byte=0xA5 and o_frame_err=0.
  - Required: o_rx_active=0 after the strobe.
- Glitch: drive i_rx_serial low for 4 clocks, then high.
  - Required: o_rx_active pulses, then returns to 0 with no o_rx_done. o_rx_byte keeps its previous value.
- Framing error: send 0x3C with the stop bit driven 0.
  - Required: o_rx_done with o_rx_byte=0x3C and o_frame_err=1.
  - Then send 0x55 with a valid stop bit. Required: o_frame_err=0.
- Back-to-back: send 0x00 immediately followed by 0xFF with no idle gap.
  - Required: exactly two o_rx_done strobes carrying 0x00 then 0xFF, both with frame_err=0.
- Slow tick and reset:
  - Set i_bd to one pulse every 5 clocks and send 0x81. Required: o_rx_byte=0x81.
  - Assert i_reset for 1 cycle in the middle of data bit 3 of the next frame. Required: the next cycle shows o_rx_active=0 and o_rx_byte=0, with no strobe.
  - Then send 0x7E. Required: received correctly.
